// File: rtl/d_branch_sched.sv
// D-stage branch scheduler: 2-bit saturating direction table, resolution/redirect, 2-stage table write.
// Optional BRANCH_SCHED_STATS_EN adds resolution and mispredict counters.
module d_branch_sched #(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_pc,
    input  logic        F_is_br,
    output logic        F_pred_taken,
    input  logic [31:0] D_pc,
    input  logic        D_is_br,
    input  logic        D_likely,
    input  logic        D_pred_taken,
    input  logic        D_branch,
    input  logic        stall,
    output logic        D_mispredict,
    output logic        D_redirect_taken,
    output logic        D_cleardb,
    output logic        busy_upd
`ifdef BRANCH_SCHED_STATS_EN
    ,
    output logic [31:0] stat_br,
    output logic [31:0] stat_miss
`endif
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       ctr [DEPTH];
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [1:0]       wb_val;

    logic [IDX_W-1:0] F_idx;
    logic [IDX_W-1:0] D_idx;
    logic [1:0]       F_ctr;
    logic [1:0]       D_ctr;
    logic             accept;
    logic             unused_pc_bits;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken && c != 2'b11)
            r = c + 2'b01;
        else if (!taken && c != 2'b00)
            r = c - 2'b01;
        return r;
    endfunction

    assign F_idx = F_pc[IDX_W+1:2];
    assign D_idx = D_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{F_pc[31:IDX_W+2], F_pc[1:0], D_pc[31:IDX_W+2], D_pc[1:0]};

    // Pending write is forwarded to both readers so back-to-back updates accumulate.
    always_comb begin
        F_ctr = ctr[F_idx];
        if (wb_valid && wb_idx == F_idx)
            F_ctr = wb_val;
        D_ctr = ctr[D_idx];
        if (wb_valid && wb_idx == D_idx)
            D_ctr = wb_val;
    end

    assign accept = D_is_br & ~stall;

    always_comb begin
        F_pred_taken     = F_is_br & F_ctr[1];
        D_mispredict     = 1'b0;
        D_redirect_taken = 1'b0;
        D_cleardb        = 1'b0;
        if (accept) begin
            D_mispredict     = D_branch ^ D_pred_taken;
            D_redirect_taken = D_branch;
            D_cleardb        = D_likely & ~D_branch;
        end
    end

    assign busy_upd = wb_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                ctr[i] <= INIT_CTR;
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_val   <= '0;
        end else begin
            if (wb_valid)
                ctr[wb_idx] <= wb_val;
            wb_valid <= accept;
            if (accept) begin
                wb_idx <= D_idx;
                wb_val <= sat(D_ctr, D_branch);
            end
        end
    end

`ifdef BRANCH_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br   <= '0;
            stat_miss <= '0;
        end else if (accept) begin
            stat_br <= stat_br + 32'd1;
            if (D_mispredict)
                stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_branch_sched.sv
// Self-checking bench for d_branch_sched: directed scenarios plus random traffic against
// a table model whose updates become visible in the cycle after resolution.
module tb_d_branch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] F_pc;
    logic        F_is_br;
    logic        F_pred_taken;
    logic [31:0] D_pc;
    logic        D_is_br;
    logic        D_likely;
    logic        D_pred_taken;
    logic        D_branch;
    logic        stall;
    logic        D_mispredict;
    logic        D_redirect_taken;
    logic        D_cleardb;
    logic        busy_upd;
`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_miss;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int model [64];
    logic exp_busy;
    int exp_br;
    int exp_miss;

    always #5 clk = ~clk;

    d_branch_sched #(.IDX_W(6), .INIT_CTR(2'b01)) dut (
        .clk              (clk),
        .reset            (reset),
        .F_pc             (F_pc),
        .F_is_br          (F_is_br),
        .F_pred_taken     (F_pred_taken),
        .D_pc             (D_pc),
        .D_is_br          (D_is_br),
        .D_likely         (D_likely),
        .D_pred_taken     (D_pred_taken),
        .D_branch         (D_branch),
        .stall            (stall),
        .D_mispredict     (D_mispredict),
        .D_redirect_taken (D_redirect_taken),
        .D_cleardb        (D_cleardb),
        .busy_upd         (busy_upd)
`ifdef BRANCH_SCHED_STATS_EN
        ,
        .stat_br          (stat_br),
        .stat_miss        (stat_miss)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    function automatic int sat_model(input int c, input logic taken);
        if (taken) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 1;
        exp_busy = 1'b0;
        exp_br   = 0;
        exp_miss = 0;
    endtask

    // Called at posedge+1 with inputs already driven; checks, then advances one clock.
    task automatic cycle(input string tag);
        logic acc;
        logic e_pred;
        #1;
        acc    = D_is_br && !stall;
        e_pred = F_is_br && (model[idx_of(F_pc)] >= 2);
        chk({tag, "_pred"},  F_pred_taken, e_pred);
        chk({tag, "_mis"},   D_mispredict, acc && (D_branch != D_pred_taken));
        chk({tag, "_redir"}, D_redirect_taken, acc && D_branch);
        chk({tag, "_cldb"},  D_cleardb, acc && D_likely && !D_branch);
        chk({tag, "_busy"},  busy_upd, exp_busy);
`ifdef BRANCH_SCHED_STATS_EN
        chk({tag, "_sbr"},   stat_br, exp_br);
        chk({tag, "_smiss"}, stat_miss, exp_miss);
`endif
        @(posedge clk);
        if (acc) begin
            model[idx_of(D_pc)] = sat_model(model[idx_of(D_pc)], D_branch);
            exp_br++;
            if (D_branch != D_pred_taken) exp_miss++;
        end
        exp_busy = acc;
        #1;
    endtask

    task automatic drive(input logic [31:0] fpc, input logic fbr, input logic [31:0] dpc,
                         input logic dbr, input logic lk, input logic pt, input logic tk,
                         input logic st);
        F_pc = fpc; F_is_br = fbr; D_pc = dpc; D_is_br = dbr;
        D_likely = lk; D_pred_taken = pt; D_branch = tk; stall = st;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and first mispredict at 0x3000
        drive(32'h3000, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rst_pred", F_pred_taken, 1'b0);
        chk("rst_busy", busy_upd, 1'b0);
        chk("first_mis", D_mispredict, 1'b1);
        chk("first_redir", D_redirect_taken, 1'b1);
        #0;
        cycle("first");

        // Three back-to-back taken at 0x3010, then lookup, then a fourth
        for (int i = 0; i < 3; i++) begin
            drive(32'h3010, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            cycle("b2b");
        end
        drive(32'h3010, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("sat_pred", F_pred_taken, 1'b1);
        cycle("sat_look");
        drive(32'h3010, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("sat4");
        drive(32'h3010, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("sat_hold");
        chk("sat_model", model[idx_of(32'h3010)], 3);

        // Likely branch not taken: clears delay slot; stalled copy does nothing
        drive(32'h3030, 1'b1, 32'h3030, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("lk_stall_cldb", D_cleardb, 1'b0);
        cycle("lk_stall");
        drive(32'h3030, 1'b1, 32'h3030, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("lk_cldb", D_cleardb, 1'b1);
        cycle("lk");

        // Bypass: resolve at 0x3020 then look up the very next cycle
        drive(32'h0, 1'b0, 32'h3020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("byp_res");
        drive(32'h3020, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("byp_pred", F_pred_taken, 1'b1);
        cycle("byp_look");

        // Stall for 3 cycles then release: exactly one update
        for (int i = 0; i < 3; i++) begin
            drive(32'h3040, 1'b1, 32'h3040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            cycle("stall");
        end
        drive(32'h3040, 1'b1, 32'h3040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("unstall");
        drive(32'h3040, 1'b1, 32'h3044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("stall_after");
        chk("stall_once", model[idx_of(32'h3040)], 2);

        // Random traffic over a small PC window to force index collisions
        for (int i = 0; i < 300; i++) begin
            drive(32'h3000 + 32'(4 * $urandom_range(0, 7)), 1'($urandom),
                  32'h3000 + 32'(4 * $urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            cycle("rnd");
        end

        // Reset while a write is pending
        drive(32'h3010, 1'b1, 32'h3010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("pre_rst");
        chk("pre_rst_busy", busy_upd, 1'b1);
        D_is_br = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy_upd, 1'b0);
        chk("mid_rst_pred", F_pred_taken, 1'b0);
        chk("mid_rst_mis", D_mispredict, 1'b0);
        chk("mid_rst_cldb", D_cleardb, 1'b0);
`ifdef BRANCH_SCHED_STATS_EN
        chk("mid_rst_sbr", stat_br, 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive(32'h3000 + 32'(4 * i), 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle("post_rst");
        end

        // Five resolutions including two misses
        for (int i = 0; i < 5; i++) begin
            drive(32'h3050, 1'b0, 32'h3050, 1'b1, 1'b0, (i >= 2), 1'b1, 1'b0);
            cycle("stats");
        end
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("stats_end");
`ifdef BRANCH_SCHED_STATS_EN
        chk("stat_br5", stat_br, 5);
        chk("stat_miss2", stat_miss, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/d_branch_sched.md
Name: d_branch_sched

Overview:
- Branch scheduling controller for the D-stage branch comparator in the 5-stage MIPS pipeline.
- Holds a direct-mapped table of 2-bit saturating direction counters. F stage looks up a prediction; D stage resolves it against the comparator's `D_branch` result.
- Drives the next-PC redirect, the delay-slot annul for likely-type branches, and updates the table.
- Sits between F/D pipeline registers, the NPC mux and the comparator.

Parameters:
- `IDX_W`, 6, table index width; the table has 2^IDX_W entries.
- `INIT_CTR`, 2'b01, counter reset value (weakly not-taken).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `F_pc`  in  32  PC of the instruction in F
- `F_is_br`  in  1  predecoded: F instruction is a conditional branch
- `F_pred_taken`  out  1  prediction for the F instruction; travels down the F/D register
- `D_pc`  in  32  PC of the instruction in D
- `D_is_br`  in  1  D instruction is a conditional branch
- `D_likely`  in  1  D branch annuls its delay slot when not taken
- `D_pred_taken`  in  1  prediction carried from F through the F/D register
- `D_branch`  in  1  comparator resolution (1 = taken)
- `stall`  in  1  D stage held by the hazard unit this cycle
- `D_mispredict`  out  1  redirect the NPC mux to the correct path
- `D_redirect_taken`  out  1  valid with `D_mispredict`; 1 selects branch target, 0 selects `D_pc`+8
- `D_cleardb`  out  1  flush the delay-slot instruction currently in F
- `busy_upd`  out  1  a table write is pending in the write-back register

Behaviour:
- Index: `idx = pc[IDX_W+1:2]`. `F_idx` comes from `F_pc`, `D_idx` from `D_pc`.
- Reset (async): every counter = `INIT_CTR`; write-back register invalid; `busy_upd` = 0.
  - Combinational outputs follow their inputs, so after reset `F_pred_taken` = `INIT_CTR[1]` = 0.
- Lookup (combinational):
  - `F_pred_taken = F_is_br & ctr[F_idx][1]`.
  - Bypass: if the write-back register is valid and `wb_idx == F_idx`, use the pending new counter instead of the stored one.
- Resolution (combinational, only when `D_is_br & !stall`):
  - `D_mispredict = D_branch ^ D_pred_taken`.
  - `D_redirect_taken = D_branch`.
  - `D_cleardb = D_likely & !D_branch`.
  - While `stall` = 1 or `D_is_br` = 0, all three outputs are 0.
- Update pipeline, 2-stage write:
  - Cycle N (resolution accepted): capture `wb_idx = D_idx` and `wb_val = sat(ctr[D_idx], D_branch)`; set write-back valid, `busy_upd` = 1.
  - Cycle N+1: commit `wb_val` into `ctr[wb_idx]`. Valid clears unless a new resolution is captured in the same cycle.
- Saturation: taken increments and not-taken decrements, clamped to [00, 11]. No wrap from 11 to 00 or from 00 to 11.
- Back-to-back branches hitting the same index: the stage-1 read uses the bypassed `wb_val`, so consecutive updates accumulate correctly.
- Stall held across many cycles: no capture occurs, and the resolution is taken once, in the first cycle `stall` = 0.
- Reset asserted mid-update: the pending write is discarded and the table reinitialised.
- Latency:
  - Prediction: 0 cycles.
  - Resolution outputs: 0 cycles.
  - Table visible to lookup: the next cycle via bypass, 2 cycles via storage.

Optional Feature:
- Macro: `BRANCH_SCHED_STATS_EN`.
- Defined: adds outputs `stat_br` [31:0] and `stat_miss` [31:0].
  - Both reset to 0 asynchronously.
  - `stat_br` increments on each accepted resolution; `stat_miss` increments when `D_mispredict` = 1.
  - Both wrap modulo 2^32.
- Undefined: those ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then `F_is_br`=1 with `F_pc`=0x3000 → `F_pred_taken`=0; `D_branch`=1, `D_pred_taken`=0 at `D_pc`=0x3000 → `D_mispredict`=1, `D_redirect_taken`=1.
- Three consecutive taken resolutions at `D_pc`=0x3010 on back-to-back cycles → counter reaches 11 (01→10→11→11); next lookup at 0x3010 → `F_pred_taken`=1; a fourth taken resolution keeps it at 11.
- `D_likely`=1, `D_branch`=0, `stall`=0 → `D_cleardb`=1; same inputs with `stall`=1 → `D_cleardb`=0, `D_mispredict`=0, no table change.
- Resolution at `D_pc`=0x3020 in cycle N; lookup at `F_pc`=0x3020 in cycle N+1 → sees the bypassed value.
- `stall` held for 3 cycles with a taken branch in D → exactly one counter update, after `stall` falls.
- Assert `reset` while `busy_upd`=1 → all outputs low, counters back to 01; with `BRANCH_SCHED_STATS_EN` defined, after 5 resolutions including 2 misses → `stat_br`=5, `stat_miss`=2.
